// File: rtl/dmem_if.sv
// Load/store bus between the CPU and its data-memory target.
// Request channel (valid/ready) carries op, mode, address and store data.
// Response channel (valid/ready) carries load data and an error flag.
interface dmem_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_mode;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_we, req_mode, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_mode, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores with RISC-V funct3 modes.
// Latency: response valid LATENCY+1 cycles after the accept cycle; one request in flight.
// Backpressure: req_ready low from accept until the response handshake; response held until rsp_ready.
module dmem_responder #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 17,
  parameter int LATENCY   = 1
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t               state;
  logic [3:0]           cnt;
  logic                 l_we;
  logic [2:0]           l_mode;
  logic [ADDR_BITS-1:0] l_addr;
  logic [WIDTH-1:0]     l_wdata;

  logic [7:0] mem [0:(1 << ADDR_BITS) - 1];

  // Access operands: with zero latency the access happens on the accept edge,
  // so the live bus is used; otherwise the latched copy.
  logic                 a_we;
  logic [2:0]           a_mode;
  logic [ADDR_BITS-1:0] a0, a1, a2, a3;
  logic [WIDTH-1:0]     a_wdata;
  logic                 access;
  logic                 err;
  logic [7:0]           b0, b1, b2, b3;
  logic [WIDTH-1:0]     load_val;
  logic [WIDTH-1:0]     rdata_next;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[WIDTH-1:ADDR_BITS];

  // Select operands, decode errors and build the extended load value.
  always_comb begin
    a_we    = l_we;
    a_mode  = l_mode;
    a0      = l_addr;
    a_wdata = l_wdata;
    if (state == IDLE) begin
      a_we    = bus.req_we;
      a_mode  = bus.req_mode;
      a0      = bus.req_addr[ADDR_BITS-1:0];
      a_wdata = bus.req_wdata;
    end
    a1 = a0 + ADDR_BITS'(1);
    a2 = a0 + ADDR_BITS'(2);
    a3 = a0 + ADDR_BITS'(3);

    if (LATENCY == 0) access = (state == IDLE) && bus.req_valid;
    else              access = (state == WAIT) && (cnt == 4'd0);

    err = 1'b0;
    case (a_mode)
      3'b000:  err = 1'b0;
      3'b001:  err = a0[0];
      3'b010:  err = (a0[1:0] != 2'b00);
      3'b100:  err = a_we;
      3'b101:  err = a_we | a0[0];
      default: err = 1'b1;
    endcase

    b0 = mem[a0];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    case (a_mode)
      3'b000:  load_val = {{(WIDTH-8){b0[7]}}, b0};
      3'b100:  load_val = {{(WIDTH-8){1'b0}}, b0};
      3'b001:  load_val = {{(WIDTH-16){b1[7]}}, b1, b0};
      3'b101:  load_val = {{(WIDTH-16){1'b0}}, b1, b0};
      3'b010:  load_val = WIDTH'({b3, b2, b1, b0});
      default: load_val = '0;
    endcase
    rdata_next = (err || a_we) ? '0 : load_val;
  end

  // Store commit on the edge entering RESP; only bytes covered by the mode change.
  always_ff @(posedge clk) begin
    if (!rst && access && a_we && !err) begin
      mem[a0] <= a_wdata[7:0];
      if (a_mode[1:0] != 2'b00) mem[a1] <= a_wdata[15:8];
      if (a_mode[1:0] == 2'b10) begin
        mem[a2] <= a_wdata[23:16];
        mem[a3] <= a_wdata[31:24];
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      l_we          <= 1'b0;
      l_mode        <= 3'b000;
      l_addr        <= '0;
      l_wdata       <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            l_we          <= bus.req_we;
            l_mode        <= bus.req_mode;
            l_addr        <= bus.req_addr[ADDR_BITS-1:0];
            l_wdata       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= rdata_next;
              bus.rsp_err   <= err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= rdata_next;
            bus.rsp_err   <= err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of load/store transactions
// plus hand-written sequences for response stall and reset during WAIT.
module tb_dmem_responder;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  dmem_if #(.WIDTH(32)) bus ();

  dmem_responder #(.WIDTH(32), .ADDR_BITS(17), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One full transaction; scrambles the request inputs right after accept.
  task automatic txn(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata,
                     output logic err, output int lat);
    int n;
    @(negedge clk);
    bus.req_we    = we;
    bus.req_mode  = mode;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_mode  = 3'(mode + 3'd1);
    bus.req_addr  = addr ^ 32'h4;
    bus.req_wdata = $urandom;
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  vec_t        vecs[$];
  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_mode  = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    vecs.push_back('{"sw_100",      1'b1, 3'b010, 32'h100,   32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{"lw_100",      1'b0, 3'b010, 32'h100,   32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{"lb_103",      1'b0, 3'b000, 32'h103,   32'h0,        32'hFFFFFFDE, 1'b0});
    vecs.push_back('{"lbu_103",     1'b0, 3'b100, 32'h103,   32'h0,        32'h000000DE, 1'b0});
    vecs.push_back('{"lh_100",      1'b0, 3'b001, 32'h100,   32'h0,        32'hFFFFBEEF, 1'b0});
    vecs.push_back('{"lhu_102",     1'b0, 3'b101, 32'h102,   32'h0,        32'h0000DEAD, 1'b0});
    vecs.push_back('{"sb_101",      1'b1, 3'b000, 32'h101,   32'hAAAAAA12, 32'h0,        1'b0});
    vecs.push_back('{"lw_after_sb", 1'b0, 3'b010, 32'h100,   32'h0,        32'hDEAD12EF, 1'b0});
    vecs.push_back('{"lw_mis",      1'b0, 3'b010, 32'h102,   32'h0,        32'h0,        1'b1});
    vecs.push_back('{"sh_mis",      1'b1, 3'b001, 32'h101,   32'h5555,     32'h0,        1'b1});
    vecs.push_back('{"lw_unchg",    1'b0, 3'b010, 32'h100,   32'h0,        32'hDEAD12EF, 1'b0});
    vecs.push_back('{"mode_011",    1'b0, 3'b011, 32'h100,   32'h0,        32'h0,        1'b1});
    vecs.push_back('{"sbu_err",     1'b1, 3'b100, 32'h100,   32'h0,        32'h0,        1'b1});
    vecs.push_back('{"lw_unchg2",   1'b0, 3'b010, 32'h100,   32'h0,        32'hDEAD12EF, 1'b0});
    vecs.push_back('{"lw_wrap",     1'b0, 3'b010, 32'h20100, 32'h0,        32'hDEAD12EF, 1'b0});
    vecs.push_back('{"sh_top",      1'b1, 3'b001, 32'h1FFFE, 32'h12348001, 32'h0,        1'b0});
    vecs.push_back('{"lh_top",      1'b0, 3'b001, 32'h1FFFE, 32'h0,        32'hFFFF8001, 1'b0});
    vecs.push_back('{"lb_top",      1'b0, 3'b000, 32'h1FFFF, 32'h0,        32'hFFFFFF80, 1'b0});

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Vector table
    foreach (vecs[i]) begin
      txn(vecs[i].we, vecs[i].mode, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(LAT + 1));
    end

    // Response stall: held stable, new request ignored until handshake
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_mode = 3'b010; bus.req_addr = 32'h100; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_we = 1'b1; bus.req_wdata = 32'h0;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rsp_rdata", bus.rsp_rdata, 32'hDEAD12EF);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
    txn(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat);
    chk("stall_store_ignored", rd, 32'hDEAD12EF);

    // Reset during WAIT discards the pending store
    txn(1'b1, 3'b010, 32'h200, 32'hCAFEF00D, rd, er, lat);
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_mode = 3'b010; bus.req_addr = 32'h200;
    bus.req_wdata = 32'h1; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("wait_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rsp_err",   32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 3'b010, 32'h200, 32'h0, rd, er, lat);
    chk("midrst_no_write", rd, 32'hCAFEF00D);
    chk("midrst_lw_err", 32'(er), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
